sha256_round_sequencer: RTL and testbench

- Iterative controller that runs one 512-bit SHA-256 block through a single shared, external round datapath (compression step with K lookup) over 64 rounds.
- Accepts the block and its chaining hash over a valid/ready handshake.
- Generates round index and message-schedule words (W expansion internal), holds the working state a..h, performs the final per-word addition with the chaining hash, and returns the digest over valid/ready.
- Sits between the message padder/block buffer and the round datapath.

---
 rtl/sha256_round_sequencer.sv | 150 +++++++++++++++
 tb/tb_sha256_round_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_sequencer
// Purpose  : Iterates one SHA-256 block over 64 rounds through an external
//            round datapath; expands W, holds a..h, forms the final digest.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_round_sequencer #(
    parameter int ROUND_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic [255:0] in_hash,
    output logic         rnd_start,
    output logic [5:0]   rnd_round,
    output logic [31:0]  rnd_w,
    output logic [255:0] rnd_hash,
    input  logic [255:0] rnd_hash_next,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_round_lat = ROUND_LAT[1:0];
    localparam logic [5:0] c_last_round = 6'd63;

    state_t         r_state;
    logic [5:0]     r_round;
    logic [1:0]     r_wait;
    logic [511:0]   r_window;
    logic [255:0]   r_work;
    logic [255:0]   r_chain;
    logic [255:0]   r_digest;
    logic           r_out_valid;
    logic           r_in_ready;
    logic           r_rnd_start;

    logic [31:0]    w_w0;
    logic [31:0]    w_w1;
    logic [31:0]    w_w9;
    logic [31:0]    w_w14;
    logic [31:0]    w_sig0;
    logic [31:0]    w_sig1;
    logic [31:0]    w_wn;
    logic           w_last_wait;
    logic [255:0]   w_sum;

    // The window always holds W[t..t+15]; word 0 sits in the top bits.
    assign w_w0  = r_window[511:480];
    assign w_w1  = r_window[479:448];
    assign w_w9  = r_window[223:192];
    assign w_w14 = r_window[63:32];

    assign w_sig0 = {w_w1[6:0], w_w1[31:7]} ^ {w_w1[17:0], w_w1[31:18]} ^ {3'b000, w_w1[31:3]};
    assign w_sig1 = {w_w14[16:0], w_w14[31:17]} ^ {w_w14[18:0], w_w14[31:19]} ^ {10'd0, w_w14[31:10]};
    assign w_wn   = w_sig1 + w_w9 + w_sig0 + w_w0;

    assign w_last_wait = (r_wait == c_round_lat);

    generate
        for (genvar i = 0; i < 8; i++) begin : g_add
            assign w_sum[32*i +: 32] = r_work[32*i +: 32] + r_chain[32*i +: 32];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_round     <= 6'd0;
            r_wait      <= 2'd0;
            r_window    <= '0;
            r_work      <= '0;
            r_chain     <= '0;
            r_digest    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_rnd_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_rnd_start <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_window    <= in_block;
                        r_work      <= in_hash;
                        r_chain     <= in_hash;
                        r_round     <= 6'd0;
                        r_wait      <= 2'd0;
                        r_in_ready  <= 1'b0;
                        r_rnd_start <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_last_wait) begin
                        r_wait      <= r_wait + 2'd1;
                        r_rnd_start <= 1'b0;
                    end else begin
                        // Datapath result is only trusted on the last wait cycle.
                        r_work   <= rnd_hash_next;
                        r_window <= {r_window[479:0], w_wn};
                        r_wait   <= 2'd0;
                        if (r_round == c_last_round) begin
                            r_rnd_start <= 1'b0;
                            r_state     <= S_ADD;
                        end else begin
                            r_round     <= r_round + 6'd1;
                            r_rnd_start <= 1'b1;
                        end
                    end
                end
                S_ADD: begin
                    r_digest    <= w_sum;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign rnd_start  = r_rnd_start;
    assign rnd_round  = r_round;
    assign rnd_w      = w_w0;
    assign rnd_hash   = r_work;
    assign out_valid  = r_out_valid;
    assign out_digest = r_digest;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sha256_round_sequencer
// Purpose  : Scoreboard bench for sha256_round_sequencer with a golden round
//            datapath, at ROUND_LAT=0 and ROUND_LAT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_round_sequencer;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] c_IV       = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] c_TWO_DIG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] c_ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] c_EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [511:0] c_BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] c_BLK2 = {480'd0, 32'h000001c0};

    logic         clk;
    logic         rst;
    logic         in_valid0, in_ready0, rnd_start0, out_valid0, out_ready0, busy0;
    logic [511:0] in_block0;
    logic [255:0] in_hash0, rnd_hash0, rnd_hash_next0, out_digest0;
    logic [5:0]   rnd_round0;
    logic [31:0]  rnd_w0;
    logic         in_valid2, in_ready2, rnd_start2, out_valid2, out_ready2, busy2;
    logic [511:0] in_block2;
    logic [255:0] in_hash2, rnd_hash2, rnd_hash_next2, out_digest2;
    logic [5:0]   rnd_round2;
    logic [31:0]  rnd_w2;

    logic [255:0] exp0_q [$];
    logic [255:0] exp2_q [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           ph2 = 0;
    logic [31:0]  cap_w16, cap_w17;

    sha256_round_sequencer #(.ROUND_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_block(in_block0), .in_hash(in_hash0), .rnd_start(rnd_start0),
        .rnd_round(rnd_round0), .rnd_w(rnd_w0), .rnd_hash(rnd_hash0),
        .rnd_hash_next(rnd_hash_next0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_digest(out_digest0), .busy(busy0)
    );

    sha256_round_sequencer #(.ROUND_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_block(in_block2), .in_hash(in_hash2), .rnd_start(rnd_start2),
        .rnd_round(rnd_round2), .rnd_w(rnd_w2), .rnd_hash(rnd_hash2),
        .rnd_hash_next(rnd_hash_next2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_digest(out_digest2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [5:0] t, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [31:0] sha_w(input logic [511:0] blk, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = blk[511 - 32*i -: 32];
            else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                        + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        return w[t];
    endfunction

    function automatic logic [255:0] sha_compress(input logic [511:0] blk, input logic [255:0] h);
        logic [255:0] s, r;
        s = h;
        for (int t = 0; t < 64; t++) s = round_fn(s, 6'(t), sha_w(blk, t));
        for (int i = 0; i < 8; i++) r[32*i +: 32] = s[32*i +: 32] + h[32*i +: 32];
        return r;
    endfunction

    // Golden datapath; the latency-2 one is only correct on the final wait cycle.
    always_comb rnd_hash_next0 = round_fn(rnd_hash0, rnd_round0, rnd_w0);
    always_comb begin
        rnd_hash_next2 = round_fn(rnd_hash2, rnd_round2, rnd_w2);
        if (rnd_start2 || ph2 != 2) rnd_hash_next2 = ~rnd_hash_next2;
    end
    always @(posedge clk) ph2 <= rnd_start2 ? 1 : ph2 + 1;

    task automatic send0(input logic [511:0] blk, input logic [255:0] h, input logic [255:0] expd);
        int g = 0;
        @(negedge clk);
        while (!in_ready0 && g < 500) begin @(negedge clk); g++; end
        n_vec++;
        if (!in_ready0) begin n_err++; $display("FAIL send0_ready: in_ready=%b required 1", in_ready0); end
        in_valid0 = 1'b1; in_block0 = blk; in_hash0 = h;
        exp0_q.push_back(expd);
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_block0 = ~blk; in_hash0 = ~h;
    endtask

    task automatic wait_out0(input int exp_lat, input bit chk, input logic [511:0] blk);
        int n = 0;
        while (!out_valid0 && n < 1000) begin
            if (chk && n < 64) begin
                n_vec++;
                if (rnd_round0 !== 6'(n) || rnd_w0 !== sha_w(blk, n) || rnd_start0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL sched_t%0d: round=%0d w=%h start=%b required round=%0d w=%h start=1",
                             n, rnd_round0, rnd_w0, rnd_start0, n, sha_w(blk, n));
                end
                if (n == 16) cap_w16 = rnd_w0;
                if (n == 17) cap_w17 = rnd_w0;
            end
            @(posedge clk); #1; n++;
        end
        n_vec++;
        if (!out_valid0 || n != exp_lat) begin
            n_err++; $display("FAIL latency0: edges=%0d out_valid=%b required %0d", n, out_valid0, exp_lat);
        end
    endtask

    task automatic recv0(output logic [255:0] d);
        int g = 0;
        logic [255:0] e = 'x;
        @(negedge clk);
        while (!out_valid0 && g < 1000) begin @(negedge clk); g++; end
        n_vec++;
        if (exp0_q.size() > 0) e = exp0_q.pop_front();
        if (!out_valid0 || out_digest0 !== e) begin
            n_err++; $display("FAIL digest0: valid=%b got %h required %h", out_valid0, out_digest0, e);
        end
        d = out_digest0;
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
    endtask

    task automatic send2(input logic [511:0] blk, input logic [255:0] h, input logic [255:0] expd);
        int g = 0;
        @(negedge clk);
        while (!in_ready2 && g < 500) begin @(negedge clk); g++; end
        n_vec++;
        if (!in_ready2) begin n_err++; $display("FAIL send2_ready: in_ready=%b required 1", in_ready2); end
        in_valid2 = 1'b1; in_block2 = blk; in_hash2 = h;
        exp2_q.push_back(expd);
        @(posedge clk); #1;
        in_valid2 = 1'b0; in_block2 = ~blk; in_hash2 = ~h;
    endtask

    task automatic recv2(output logic [255:0] d);
        int g = 0;
        logic [255:0] e = 'x;
        @(negedge clk);
        while (!out_valid2 && g < 1000) begin @(negedge clk); g++; end
        n_vec++;
        if (exp2_q.size() > 0) e = exp2_q.pop_front();
        if (!out_valid2 || out_digest2 !== e) begin
            n_err++; $display("FAIL digest2: valid=%b got %h required %h", out_valid2, out_digest2, e);
        end
        d = out_digest2;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({in_ready0, out_valid0, rnd_start0, busy0, rnd_round0, rnd_w0, rnd_hash0, out_digest0} !== '0) begin
            n_err++; $display("FAIL reset_outputs: ready=%b valid=%b start=%b busy=%b digest=%h required all 0",
                              in_ready0, out_valid0, rnd_start0, busy0, out_digest0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready0 !== 1'b1 || in_ready2 !== 1'b1 || busy0 !== 1'b0) begin
            n_err++; $display("FAIL reset_release: in_ready0=%b in_ready2=%b busy0=%b required 1 1 0", in_ready0, in_ready2, busy0);
        end
    endtask

    task automatic test_abc();
        logic [255:0] d;
        send0(c_ABC_BLK, c_IV, sha_compress(c_ABC_BLK, c_IV));
        wait_out0(65, 1'b1, c_ABC_BLK);
        recv0(d);
        n_vec++;
        if (d !== c_ABC_DIG) begin n_err++; $display("FAIL abc_digest: got %h required %h", d, c_ABC_DIG); end
        n_vec++;
        if (cap_w16 !== 32'h61626380 || cap_w17 !== 32'h000f0000) begin
            n_err++; $display("FAIL abc_w16_w17: got %h %h required 61626380 000f0000", cap_w16, cap_w17);
        end
    endtask

    task automatic test_empty_lat2();
        logic [255:0] d;
        int n = 0;
        int pulses = 0;
        send2(c_EMPTY_BLK, c_IV, sha_compress(c_EMPTY_BLK, c_IV));
        while (!out_valid2 && n < 1000) begin
            if (rnd_start2) begin
                pulses++;
                n_vec++;
                if (n % 3 != 0 || rnd_round2 !== 6'(n / 3)) begin
                    n_err++; $display("FAIL start2_pos: edge=%0d round=%0d required edge multiple of 3 and round %0d", n, rnd_round2, n / 3);
                end
            end
            @(posedge clk); #1; n++;
        end
        n_vec++;
        if (!out_valid2 || n != 193 || pulses != 64) begin
            n_err++; $display("FAIL latency2: edges=%0d pulses=%0d required 193 and 64", n, pulses);
        end
        recv2(d);
        n_vec++;
        if (d !== c_EMPTY_DIG) begin n_err++; $display("FAIL empty_digest: got %h required %h", d, c_EMPTY_DIG); end
    endtask

    task automatic test_backpressure();
        logic [255:0] d;
        send0(c_ABC_BLK, c_IV, c_ABC_DIG);
        wait_out0(65, 1'b0, c_ABC_BLK);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid0 = 1'b1; in_block0 = c_EMPTY_BLK; in_hash0 = c_IV;
            n_vec++;
            if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_digest0 !== c_ABC_DIG) begin
                n_err++; $display("FAIL hold_%0d: valid=%b in_ready=%b digest=%h required 1 0 %h",
                                  i, out_valid0, in_ready0, out_digest0, c_ABC_DIG);
            end
        end
        in_valid0 = 1'b0;
        recv0(d);
        n_vec++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_err++; $display("FAIL release: in_ready=%b out_valid=%b required 1 0", in_ready0, out_valid0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy0 !== 1'b0 || in_ready0 !== 1'b1) begin
            n_err++; $display("FAIL stray_accept: busy=%b in_ready=%b required 0 1", busy0, in_ready0);
        end
    endtask

    task automatic test_two_block();
        logic [255:0] d1, d2, m1;
        m1 = sha_compress(c_BLK1, c_IV);
        send0(c_BLK1, c_IV, m1);
        wait_out0(65, 1'b0, c_BLK1);
        recv0(d1);
        send0(c_BLK2, d1, sha_compress(c_BLK2, m1));
        wait_out0(65, 1'b0, c_BLK2);
        recv0(d2);
        n_vec++;
        if (d2 !== c_TWO_DIG) begin n_err++; $display("FAIL two_block: got %h required %h", d2, c_TWO_DIG); end
    endtask

    task automatic test_reset_midrun();
        logic [255:0] d;
        int g = 0;
        send0(c_ABC_BLK, c_IV, c_ABC_DIG);
        while (rnd_round0 !== 6'd30 && g < 200) begin @(posedge clk); #1; g++; end
        n_vec++;
        if (rnd_round0 !== 6'd30) begin n_err++; $display("FAIL reach_r30: round=%0d required 30", rnd_round0); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready0, out_valid0, rnd_start0, busy0, rnd_round0, rnd_w0, rnd_hash0, out_digest0} !== '0) begin
            n_err++; $display("FAIL midrun_reset: round=%0d start=%b busy=%b hash=%h required all 0",
                              rnd_round0, rnd_start0, busy0, rnd_hash0);
        end
        exp0_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_err++; $display("FAIL midrun_release: in_ready=%b out_valid=%b required 1 0", in_ready0, out_valid0);
        end
        send0(c_ABC_BLK, c_IV, c_ABC_DIG);
        wait_out0(65, 1'b0, c_ABC_BLK);
        recv0(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst = 1'b0;
        in_valid0 = 1'b0; in_block0 = '0; in_hash0 = '0; out_ready0 = 1'b0;
        in_valid2 = 1'b0; in_block2 = '0; in_hash2 = '0; out_ready2 = 1'b0;
        test_reset();
        test_abc();
        test_empty_lat2();
        test_backpressure();
        test_two_block();
        test_reset_midrun();
        n_vec++;
        if (exp0_q.size() != 0 || exp2_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: left %0d %0d required 0 0", exp0_q.size(), exp2_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
